// File: rtl/wbw_pkg.sv
// Shared types and sizing for the write-back memory writer: FSM states,
// response codes and the line/beat geometry.
package wbw_pkg;

  localparam int ADDR_W  = 27;
  localparam int LINE_W  = 128;
  localparam int BEAT_W  = 32;
  localparam int NBEAT   = LINE_W / BEAT_W;
  localparam int IDX_W   = $clog2(NBEAT);
  localparam int TIMEOUT = 255;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wbw_state_e;

endpackage

// File: rtl/wb_mem_writer_if.sv
// External memory write channel: address phase, data beats, write response.
// The master modport is the line writer, the slave modport is the memory side.
interface wb_mem_writer_if #(
  parameter int BEAT_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [31:0]       awaddr;
  logic              wvalid;
  logic              wready;
  logic [BEAT_W-1:0] wdata;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wlast, bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/wbw_beat_mux.sv
// Selects one data beat out of a buffered line; beat 0 is the low word.
module wbw_beat_mux #(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [BEAT_W-1:0] beat_o
);

  // Word select within the line
  always_comb begin
    beat_o = line_i[BEAT_W*int'(idx_i) +: BEAT_W];
  end

endmodule

// File: rtl/wb_mem_writer.sv
// Accepts one evicted line from the write-back FIFO and writes it to memory as
// an address phase, NBEAT data beats and a response; busy until the response.
module wb_mem_writer
  import wbw_pkg::*;
#(
  parameter int ADDR_W  = wbw_pkg::ADDR_W,
  parameter int LINE_W  = wbw_pkg::LINE_W,
  parameter int BEAT_W  = wbw_pkg::BEAT_W,
  parameter int TIMEOUT = wbw_pkg::TIMEOUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [LINE_W-1:0]   wr_data,
  output logic                wr_busy,
  output logic                wr_err,
  wb_mem_writer_if.master     mem
);

  localparam int NB    = LINE_W / BEAT_W;
  localparam int IW    = $clog2(NB);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  wbw_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic [BEAT_W-1:0] wdata_q, wdata_d;
  logic              bready_q, bready_d;
  logic              err_q, err_d;

  logic [LINE_W-1:0] mux_line_s;
  logic [IW-1:0]     mux_idx_s;
  logic [BEAT_W-1:0] beat_s;

  wbw_beat_mux #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (IW)
  ) u_beat_mux (
    .line_i (mux_line_s),
    .idx_i  (mux_idx_s),
    .beat_o (beat_s)
  );

  // The wr_en term covers a request issued off the last idle cycle's low busy
  assign wr_busy     = (state_q != ST_IDLE) | wr_en;
  assign wr_err      = err_q;
  assign mem.awvalid = awvalid_q;
  assign mem.awaddr  = awaddr_q;
  assign mem.wvalid  = wvalid_q;
  assign mem.wdata   = wdata_q;
  assign mem.wlast   = wlast_q;
  assign mem.bready  = bready_q;

  // Next-state and next-output computation for the line write sequence
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    line_d     = line_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    wdata_d    = wdata_q;
    bready_d   = bready_q;
    err_d      = err_q;
    mux_line_s = line_q;
    mux_idx_s  = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          line_d     = wr_data;
          awaddr_d   = 32'({wr_addr, 4'b0000});
          awvalid_d  = 1'b1;
          idx_d      = IW'(0);
          tmo_d      = TMO_W'(0);
          // Line register is not loaded yet, so take beat 0 straight from the port
          mux_line_s = wr_data;
          mux_idx_s  = IW'(0);
          wdata_d    = beat_s;
          state_d    = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (mem.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = 1'b0;
          state_d   = ST_DATA;
        end else begin
          awvalid_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (mem.wready && (idx_q == IW'(NB - 1))) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
          idx_d    = IW'(0);
          tmo_d    = TMO_W'(0);
          state_d  = ST_RESP;
        end else if (mem.wready) begin
          idx_d     = idx_q + IW'(1);
          mux_idx_s = idx_q + IW'(1);
          wdata_d   = beat_s;
          wlast_d   = ((idx_q + IW'(1)) == IW'(NB - 1));
        end else begin
          wvalid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (mem.bvalid) begin
          err_d    = err_q | (mem.bresp != BRESP_OKAY);
          bready_d = 1'b0;
          tmo_d    = TMO_W'(0);
          state_d  = ST_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th spent waiting for the response
          err_d    = 1'b1;
          bready_d = 1'b0;
          tmo_d    = TMO_W'(0);
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wlast_d   = 1'b0;
        bready_d  = 1'b0;
      end
    endcase

    err_d = err_d | (wr_en && (state_q != ST_IDLE));
  end

  // State, line buffer and registered channel outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      idx_q     <= IW'(0);
      tmo_q     <= TMO_W'(0);
      line_q    <= LINE_W'(0);
      awaddr_q  <= 32'h0000_0000;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= BEAT_W'(0);
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      line_q    <= line_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      wdata_q   <= wdata_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_writer.sv
// Self-checking bench for wb_mem_writer: table-driven lines plus hand-written
// latency, reset, backpressure, back-to-back, error and timeout sequences.
module tb_wb_mem_writer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         wr_en;
  logic [26:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_busy;
  logic         wr_err;

  wb_mem_writer_if #(.BEAT_W(32)) mem_if ();

  wb_mem_writer dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_busy (wr_busy),
    .wr_err  (wr_err),
    .mem     (mem_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_aw[$];
  logic [32:0] exp_w[$];
  int aw_cnt     = 0;
  int beat_cnt   = 0;
  int line_beat  = 0;
  int aw_stall_left = 0;
  int w_stall_left  = 0;
  int stall_beat    = -1;

  typedef struct packed {
    logic [26:0]      addr;
    logic [127:0]     data;
    logic [31:0]      exp_aw;
    logic [3:0][31:0] exp_beat;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; memory-side ready signals are updated just after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
    if (mem_if.awvalid && aw_stall_left > 0) begin
      mem_if.awready = 1'b0;
      aw_stall_left--;
    end else begin
      mem_if.awready = 1'b1;
    end
    if (mem_if.wvalid && line_beat == stall_beat && w_stall_left > 0) begin
      mem_if.wready = 1'b0;
      w_stall_left--;
    end else begin
      mem_if.wready = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (wr_busy && n < 600) begin
      cycle();
      n++;
    end
    chk(name, 128'(n < 600), 128'd1);
  endtask

  task automatic issue(input logic [26:0] a, input logic [127:0] d,
                       input logic [31:0] eaw, input logic [3:0][31:0] eb);
    wait_idle("issue_wait");
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    exp_aw.push_back(eaw);
    for (int i = 0; i < 4; i++) exp_w.push_back({(i == 3), eb[i]});
    #1;
    chk("busy_during_wr_en", 128'(wr_busy), 128'd1);
    cycle();
    wr_en   = 1'b0;
    wr_addr = 27'($urandom);
    wr_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
  endtask

  // Scoreboard and stability monitor, sampled on the falling edge
  initial begin : monitor
    logic        aw_wait = 1'b0;
    logic        w_wait  = 1'b0;
    logic [31:0] aw_hold = 32'h0;
    logic [31:0] w_hold  = 32'h0;
    logic        wl_hold = 1'b0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_aw.delete();
        exp_w.delete();
        line_beat = 0;
        aw_wait   = 1'b0;
        w_wait    = 1'b0;
      end else begin
        if (aw_wait) begin
          chk("awvalid_held", 128'(mem_if.awvalid), 128'd1);
          chk("awaddr_stable", 128'(mem_if.awaddr), 128'(aw_hold));
        end
        if (w_wait) begin
          chk("wvalid_held", 128'(mem_if.wvalid), 128'd1);
          chk("wdata_stable", 128'(mem_if.wdata), 128'(w_hold));
          chk("wlast_stable", 128'(mem_if.wlast), 128'(wl_hold));
        end
        if (mem_if.awvalid && mem_if.awready) begin
          aw_cnt++;
          if (exp_aw.size() == 0) chk("aw_unexpected", 128'd1, 128'd0);
          else chk("awaddr", 128'(mem_if.awaddr), 128'(exp_aw.pop_front()));
        end
        if (mem_if.wvalid && mem_if.wready) begin
          beat_cnt++;
          if (exp_w.size() == 0) begin
            chk("w_unexpected", 128'd1, 128'd0);
          end else begin
            e = exp_w.pop_front();
            chk("wdata", 128'(mem_if.wdata), 128'(e[31:0]));
            chk("wlast", 128'(mem_if.wlast), 128'(e[32]));
          end
          line_beat = mem_if.wlast ? 0 : line_beat + 1;
        end
        aw_wait = mem_if.awvalid && !mem_if.awready;
        aw_hold = mem_if.awaddr;
        w_wait  = mem_if.wvalid && !mem_if.wready;
        w_hold  = mem_if.wdata;
        wl_hold = mem_if.wlast;
      end
    end
  end

  initial begin : stim
    int n;
    int aw0;
    int b0;
    logic [127:0] d;
    vecs[0] = '{27'h0000123, 128'h44443333_22221111_00000000_DEADBEEF, 32'h0000_1230,
                {32'h44443333, 32'h22221111, 32'h00000000, 32'hDEADBEEF}};
    vecs[1] = '{27'h7FFFFFF, 128'hFFFFFFFF_80000001_12345678_A5A5A5A5, 32'h7FFF_FFF0,
                {32'hFFFFFFFF, 32'h80000001, 32'h12345678, 32'hA5A5A5A5}};
    vecs[2] = '{27'h0000000, 128'h0, 32'h0000_0000,
                {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}};
    vecs[3] = '{27'h4000001, 128'h0F0F0F0F_CAFEF00D_00C0FFEE_01234567, 32'h4000_0010,
                {32'h0F0F0F0F, 32'hCAFEF00D, 32'h00C0FFEE, 32'h01234567}};

    rstn = 1'b0;
    wr_en = 1'b1;
    wr_addr = 27'h0;
    wr_data = 128'h0;
    mem_if.awready = 1'b1;
    mem_if.wready  = 1'b1;
    mem_if.bvalid  = 1'b1;
    mem_if.bresp   = 2'b00;
    #12;
    chk("busy_eq_wr_en_in_reset", 128'(wr_busy), 128'd1);
    wr_en = 1'b0;
    #1;
    chk("reset_busy", 128'(wr_busy), 128'd0);
    chk("reset_valids", 128'({mem_if.awvalid, mem_if.wvalid, mem_if.wlast, mem_if.bready}), 128'd0);
    chk("reset_err", 128'(wr_err), 128'd0);
    chk("reset_awaddr_wdata", 128'({mem_if.awaddr, mem_if.wdata}), 128'd0);
    rstn = 1'b1;
    cycle();

    // Reset in the middle of the data phase, beat index 2
    issue(vecs[3].addr, vecs[3].data, vecs[3].exp_aw, vecs[3].exp_beat);
    n = 0;
    while (!(mem_if.wvalid && line_beat == 2) && n < 20) begin
      cycle();
      n++;
    end
    chk("reach_beat2", 128'(n < 20), 128'd1);
    rstn = 1'b0;
    #1;
    chk("valids_drop_in_reset", 128'({mem_if.awvalid, mem_if.wvalid, mem_if.wlast, mem_if.bready}), 128'd0);
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
    chk("post_reset_busy", 128'(wr_busy), 128'd0);
    chk("post_reset_err", 128'(wr_err), 128'd0);
    chk("post_reset_data", 128'({mem_if.awaddr, mem_if.wdata}), 128'd0);

    // Table-driven lines, all ready signals high
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].addr, vecs[i].data, vecs[i].exp_aw, vecs[i].exp_beat);
      wait_idle("table_done");
      chk("table_err", 128'(wr_err), 128'd0);
    end

    // Minimum latency: wr_en at T, checks from T+1 onward
    issue(27'h0000123, vecs[0].data, 32'h0000_1230, vecs[0].exp_beat);
    chk("lat_awvalid_T1", 128'({mem_if.awvalid, mem_if.wvalid}), 128'b10);
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("lat_wvalid_wlast", 128'({mem_if.awvalid, mem_if.wvalid, mem_if.wlast}), 128'({1'b0, 1'b1, (k == 3)}));
      cycle();
    end
    chk("lat_bready_T6", 128'({mem_if.wvalid, mem_if.bready, wr_busy}), 128'b011);
    cycle();
    chk("lat_idle_T7", 128'({wr_busy, mem_if.bready, wr_err}), 128'b000);

    // Backpressure: awready low 3 cycles, wready low 5 cycles on beat 1
    aw0 = aw_cnt;
    b0  = beat_cnt;
    aw_stall_left = 3;
    w_stall_left  = 5;
    stall_beat    = 1;
    d = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    issue(27'h1234567, d, 32'h1234_5670, {32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98, 32'h76543210});
    wait_idle("bp_done");
    stall_beat = -1;
    chk("bp_aw_count", 128'(aw_cnt - aw0), 128'd1);
    chk("bp_beat_count", 128'(beat_cnt - b0), 128'd4);

    // Back-to-back: three queued lines from the FIFO
    aw0 = aw_cnt;
    b0  = beat_cnt;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(27'h0000100 + 27'(i), d, 32'h0000_1000 + 32'(i * 16), d);
    end
    wait_idle("b2b_done");
    chk("b2b_aw_count", 128'(aw_cnt - aw0), 128'd3);
    chk("b2b_beat_count", 128'(beat_cnt - b0), 128'd12);

    // Error response: SLVERR
    mem_if.bresp = 2'b10;
    issue(27'h0000042, vecs[1].data, 32'h0000_0420, vecs[1].exp_beat);
    n = 0;
    while (!mem_if.bready && n < 20) begin
      cycle();
      n++;
    end
    chk("err_reach_resp", 128'(n < 20), 128'd1);
    chk("err_before_resp", 128'(wr_err), 128'd0);
    cycle();
    mem_if.bresp = 2'b00;
    chk("err_set", 128'({wr_err, wr_busy}), 128'b10);
    repeat (3) cycle();
    chk("err_sticky", 128'(wr_err), 128'd1);

    // Timeout: no response ever arrives
    apply_reset();
    chk("err_cleared_by_reset", 128'(wr_err), 128'd0);
    mem_if.bvalid = 1'b0;
    issue(27'h0000777, vecs[3].data, 32'h0000_7770, vecs[3].exp_beat);
    n = 0;
    while (!mem_if.bready && n < 20) begin
      cycle();
      n++;
    end
    chk("tmo_reach_resp", 128'(n < 20), 128'd1);
    n = 0;
    while (mem_if.bready && n < 400) begin
      n++;
      cycle();
    end
    chk("tmo_resp_cycles", 128'(n), 128'd255);
    chk("tmo_err_idle", 128'({wr_err, wr_busy}), 128'b10);
    mem_if.bvalid = 1'b1;
    aw0 = aw_cnt;
    b0  = beat_cnt;
    issue(vecs[1].addr, vecs[1].data, vecs[1].exp_aw, vecs[1].exp_beat);
    wait_idle("tmo_next_done");
    chk("tmo_next_counts", 128'({aw_cnt - aw0, beat_cnt - b0}), 128'({32'd1, 32'd4}));
    chk("tmo_err_still_set", 128'(wr_err), 128'd1);

    cycle();
    chk("scoreboard_empty", 128'({exp_aw.size(), exp_w.size()}), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
